reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/cpu_pkg.sv | 14 +
 rtl/wb_fifo.sv | 68 ++++++
 rtl/reg_writeback.sv | 84 ++++++++
 tb/tb_reg_writeback.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file write-back types and widths.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back entry FIFO with per-slot valid flags exposed for match logic; head visible combinationally.
// Push lands in the cycle after the edge; push ignored when full, pop ignored when empty.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  wb_entry_t        push_dat,
  input  logic             pop_vld,
  output wb_entry_t        head_dat,
  output logic             empty,
  output logic             full,
  output logic [PTR_W-1:0] rd_ptr,
  output wb_entry_t        ent_dat [DEPTH],
  output logic [DEPTH-1:0] ent_vld
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] vld_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push_vld && !full;
  assign pop_ok  = pop_vld && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        vld_q[wr_ptr_q] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
        vld_q[rd_ptr_q] <= 1'b0;
      end
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Payload storage is never reset; valid flags alone qualify it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign rd_ptr   = rd_ptr_q;
  assign ent_dat  = mem_q;
  assign ent_vld  = vld_q;

endmodule

// File: rtl/reg_writeback.sv
// Buffers register write-backs and drains them in order to the RF write port, forwarding youngest pending data to reads.
// Accepted writes reach rf_wen one cycle later at the earliest; wb_ready drops when DEPTH entries are held, rf_busy stalls the head.
module reg_writeback
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  rf_busy,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0]     rf_wd3,
  input  logic [REG_ADDR_W-1:0] chk_a1,
  input  logic [REG_ADDR_W-1:0] chk_a2,
  output logic                  hit1,
  output logic                  hit2,
  output logic [DATA_W-1:0]     fwd1,
  output logic [DATA_W-1:0]     fwd2,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        head_dat;
  wb_entry_t        ent_dat [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_vld;
  wb_entry_t        push_dat;

  // Writes to the zero register complete the handshake but are dropped.
  assign push_vld = wb_valid && wb_ready && (wb_addr != REG_ZERO);
  assign push_dat = '{addr: wb_addr, data: wb_data};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (rf_wen),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .rd_ptr   (rd_ptr),
    .ent_dat  (ent_dat),
    .ent_vld  (ent_vld)
  );

  assign wb_ready = !fifo_full;
  assign empty    = fifo_empty;
  assign rf_wen   = !fifo_empty && !rf_busy;
  assign rf_a3    = fifo_empty ? REG_ZERO : head_dat.addr;
  assign rf_wd3   = fifo_empty ? '0 : head_dat.data;

  // Walk oldest to youngest from the read pointer so the last match wins.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [PTR_W-1:0] idx;
      idx = rd_ptr + PTR_W'(k);
      if (ent_vld[idx] && (chk_a1 != REG_ZERO) && (ent_dat[idx].addr == chk_a1)) begin
        hit1 = 1'b1;
        fwd1 = ent_dat[idx].data;
      end
      if (ent_vld[idx] && (chk_a2 != REG_ZERO) && (ent_dat[idx].addr == chk_a2)) begin
        hit2 = 1'b1;
        fwd2 = ent_dat[idx].data;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a queue-based reference model checked every falling edge.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        rf_busy = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [4:0]  chk_a1 = 5'd0;
  logic [4:0]  chk_a2 = 5'd0;
  logic        hit1, hit2;
  logic [31:0] fwd1, fwd2;
  logic        empty;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  log_a[$];
  logic [31:0] log_d[$];
  int          log_c[$];
  logic [4:0]  exp_a[$];
  logic [31:0] exp_d[$];

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rf_busy  (rf_busy),
    .rf_wen   (rf_wen),
    .rf_a3    (rf_a3),
    .rf_wd3   (rf_wd3),
    .chk_a1   (chk_a1),
    .chk_a2   (chk_a2),
    .hit1     (hit1),
    .hit2     (hit2),
    .fwd1     (fwd1),
    .fwd2     (fwd2),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Youngest pending write to a nonzero address wins.
  function automatic void model_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (a != 5'd0) begin
      foreach (mq[i]) begin
        if (mq[i].a == a) begin
          h = 1'b1;
          d = mq[i].d;
        end
      end
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (mq.size() > 0) && !rf_busy;
      do_push = wb_valid && (mq.size() < DEPTH) && (wb_addr != 5'd0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{a: wb_addr, d: wb_data});
      cyc_n++;
    end
  end

  always @(negedge clk) begin
    logic        h1, h2;
    logic [31:0] f1, f2;
    model_fwd(chk_a1, h1, f1);
    model_fwd(chk_a2, h2, f2);
    check("wb_ready", 32'(wb_ready), 32'(mq.size() < DEPTH));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("rf_wen",   32'(rf_wen),   32'((mq.size() > 0) && !rf_busy));
    check("rf_a3",    32'(rf_a3),    (mq.size() > 0) ? 32'(mq[0].a) : 32'd0);
    check("rf_wd3",   rf_wd3,        (mq.size() > 0) ? mq[0].d : 32'd0);
    check("hit1", 32'(hit1), 32'(h1));
    check("fwd1", fwd1, f1);
    check("hit2", 32'(hit2), 32'(h2));
    check("fwd2", fwd2, f2);
    if (rf_wen) begin
      log_a.push_back(rf_a3);
      log_d.push_back(rf_wd3);
      log_c.push_back(cyc_n);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] a, input logic [31:0] d);
    bit done;
    done = 1'b0;
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = wb_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    wb_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = empty;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    cyc();
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_d.delete();
    log_c.delete();
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic check_log(input bit consec);
    check("log_len", 32'(log_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
      check($sformatf("log_addr[%0d]", i), 32'(log_a[i]), 32'(exp_a[i]));
      check($sformatf("log_data[%0d]", i), log_d[i], exp_d[i]);
      if (consec && i > 0) check($sformatf("log_gap[%0d]", i), 32'(log_c[i] - log_c[i-1]), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while reset is held.
    #3;
    check("rst_wb_ready", 32'(wb_ready), 32'd1);
    check("rst_rf_wen",   32'(rf_wen),   32'd0);
    check("rst_rf_a3",    32'(rf_a3),    32'd0);
    check("rst_rf_wd3",   rf_wd3,        32'd0);
    check("rst_hit",      32'({hit1, hit2}), 32'd0);
    check("rst_fwd",      fwd1 | fwd2,   32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc();

    // Single write: no same-cycle bypass, then head presented next cycle.
    clear_logs();
    chk_a1 = 5'd8;
    wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'hDEADBEEF;
    #1;
    check("t1_no_bypass_wen", 32'(rf_wen), 32'd0);
    check("t1_no_bypass_hit", 32'(hit1),   32'd0);
    send(5'd8, 32'hDEADBEEF);
    check("t1_wen",  32'(rf_wen), 32'd1);
    check("t1_a3",   32'(rf_a3),  32'd8);
    check("t1_wd3",  rf_wd3,      32'hDEADBEEF);
    check("t1_fwd1", fwd1,        32'hDEADBEEF);
    cyc();
    check("t1_empty", 32'(empty), 32'd1);
    chk_a1 = 5'd0;

    // Fill under stall, hold the fifth, then drain all five back-to-back.
    clear_logs();
    rf_busy = 1'b1;
    for (int i = 1; i <= 4; i++) send(5'(i), 32'h100 + 32'(i));
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h105;
    #1;
    check("t2_full_ready", 32'(wb_ready), 32'd0);
    repeat (3) cyc();
    check("t2_held_ready", 32'(wb_ready), 32'd0);
    check("t2_no_writes",  32'(log_a.size()), 32'd0);
    rf_busy = 1'b0;
    send(5'd5, 32'h105);
    drain();
    for (int i = 1; i <= 5; i++) begin
      exp_a.push_back(5'(i));
      exp_d.push_back(32'h100 + 32'(i));
    end
    check_log(1'b1);

    // Zero-register write is accepted and dropped.
    clear_logs();
    chk_a1 = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    #1;
    check("t3_ready", 32'(wb_ready), 32'd1);
    cyc();
    wb_valid = 1'b0;
    check("t3_empty", 32'(empty),  32'd1);
    check("t3_wen",   32'(rf_wen), 32'd0);
    check("t3_hit1",  32'(hit1),   32'd0);
    repeat (2) cyc();
    check("t3_no_writes", 32'(log_a.size()), 32'd0);

    // Two pending writes to one register forward the younger value.
    clear_logs();
    rf_busy = 1'b1;
    send(5'd9, 32'h11);
    send(5'd9, 32'h22);
    chk_a1 = 5'd9; chk_a2 = 5'd10;
    #1;
    check("t4_hit1", 32'(hit1), 32'd1);
    check("t4_fwd1", fwd1,      32'h22);
    check("t4_hit2", 32'(hit2), 32'd0);
    check("t4_fwd2", fwd2,      32'd0);
    rf_busy = 1'b0;
    drain();
    check("t4_hit1_after", 32'(hit1), 32'd0);
    exp_a.push_back(5'd9); exp_d.push_back(32'h11);
    exp_a.push_back(5'd9); exp_d.push_back(32'h22);
    check_log(1'b1);
    chk_a1 = 5'd0; chk_a2 = 5'd0;

    // Full-rate streaming across pointer wrap: occupancy stays at one.
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      chk_a2 = 5'(11 + i);
      send(5'(11 + i), 32'h1111 * 32'(i + 1));
      check($sformatf("t5_nonempty[%0d]", i), 32'(empty),    32'd0);
      check($sformatf("t5_ready[%0d]", i),    32'(wb_ready), 32'd1);
      check($sformatf("t5_fwd2[%0d]", i),     fwd2,          32'h1111 * 32'(i + 1));
    end
    drain();
    for (int i = 0; i < 10; i++) begin
      exp_a.push_back(5'(11 + i));
      exp_d.push_back(32'h1111 * 32'(i + 1));
    end
    check_log(1'b1);
    chk_a2 = 5'd0;

    // Asynchronous reset with entries pending discards them immediately.
    clear_logs();
    rf_busy = 1'b1;
    send(5'd21, 32'hA1);
    send(5'd22, 32'hA2);
    send(5'd23, 32'hA3);
    chk_a1 = 5'd21;
    #1 rf_busy = 1'b0;
    #1;
    check("t6_pre_wen", 32'(rf_wen), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_wen",   32'(rf_wen),   32'd0);
    check("t6_empty", 32'(empty),    32'd1);
    check("t6_ready", 32'(wb_ready), 32'd1);
    check("t6_hit1",  32'(hit1),     32'd0);
    cyc();
    reset = 1'b0;
    repeat (4) cyc();
    check("t6_no_writes", 32'(log_a.size()), 32'd0);
    chk_a1 = 5'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
